// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and default constants for BIST response compaction
//
// Purpose: FSM state encoding plus the default width-4 MISR polynomial and seed,
// shared by bist_misr_analyzer, misr_next and any other BIST-path block.
// Ports: none (package).

package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // x^4 + x + 1, x^4 term implied
  localparam logic [3:0] POLY_W4 = 4'b0011;
  localparam logic [3:0] SEED_W4 = 4'b0000;

endpackage

// File: rtl/bist_misr_analyzer_if.sv
// rtl/bist_misr_analyzer_if.sv - control/sample/result bundle of the MISR analyzer
//
// Purpose: groups run control, the sample stream and the result outputs.
// Ports (signals):
//   start, sample_valid, sample_data, expected_count, golden_sig : master -> slave
//   busy, done, pass, signature, sample_count                    : slave -> master
//   timeout (only with MISR_TIMEOUT_EN)                           : slave -> master
// Modports: master (BIST controller side), slave (analyzer side).
// Configuration macro: MISR_TIMEOUT_EN adds the timeout signal.

interface bist_misr_analyzer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic [CNT_W-1:0] expected_count;
  logic [WIDTH-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] sample_count;
`ifdef MISR_TIMEOUT_EN
  logic             timeout;
`endif

  modport master (
    output start, sample_valid, sample_data, expected_count, golden_sig,
    input  busy, done, pass, signature, sample_count
`ifdef MISR_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  start, sample_valid, sample_data, expected_count, golden_sig,
    output busy, done, pass, signature, sample_count
`ifdef MISR_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/misr_next.sv
// rtl/misr_next.sv - combinational Galois-form MISR next-state function
//
// Purpose: next[i] = sig[i-1] (0 for i=0) ^ (POLY[i] & sig[WIDTH-1]) ^ data[i].
// Ports:
//   i_sig  [WIDTH] current signature
//   i_data [WIDTH] sample folded in this step
//   o_next [WIDTH] next signature

module misr_next
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_W4)
) (
  input  logic [WIDTH-1:0] i_sig,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_fb;

  assign w_shift = {i_sig[WIDTH-2:0], 1'b0};
  // Bit shifted out of the top is reinjected at every tap of the polynomial
  assign w_fb    = POLY & {WIDTH{i_sig[WIDTH-1]}};
  assign o_next  = w_shift ^ w_fb ^ i_data;

endmodule

// File: rtl/bist_misr_analyzer.sv
// rtl/bist_misr_analyzer.sv - BIST response compactor: MISR, sample counter, golden compare
//
// Purpose: folds expected_count qualified samples into a MISR, then compares the
// signature with golden_sig and reports done/pass. All outputs are registered.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   bist_misr_analyzer_if.slave (start, sample stream, expected_count,
//         golden_sig in; busy, done, pass, signature, sample_count[, timeout] out)
// Configuration macro: MISR_TIMEOUT_EN - abort a run after TIMEOUT_CYCLES
// consecutive COMPACT cycles without a sample (done=1, pass=0, timeout=1).

module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_W4),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_W4)
`ifdef MISR_TIMEOUT_EN
  , parameter int             TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bist_misr_analyzer_if.slave  bus
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sig, w_sig_nxt, w_misr;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             w_start_ok;
  logic             w_zero_run;
  logic             w_last;
  logic             w_to_hit;

`ifdef MISR_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic              r_timeout, w_timeout_nxt;
`endif

  misr_next #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr_next (
    .i_sig  (r_sig),
    .i_data (bus.sample_data),
    .o_next (w_misr)
  );

  // start only matters when no run is in flight
  assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_zero_run = (bus.expected_count == '0);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  // The sample that brings the count up to expected_count ends compaction
  assign w_last     = bus.sample_valid && (w_cnt_inc == bus.expected_count);

`ifdef MISR_TIMEOUT_EN
  assign w_to_hit = (r_state == COMPACT) && !bus.sample_valid &&
                    ((r_idle + IDLE_W'(1)) == IDLE_W'(TIMEOUT_CYCLES));
`else
  assign w_to_hit = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
`ifdef MISR_TIMEOUT_EN
      r_idle    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
`ifdef MISR_TIMEOUT_EN
      r_idle    <= w_idle_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start_ok) w_state_nxt = w_zero_run ? COMPARE : COMPACT;
      end
      COMPACT: begin
        if (w_last)        w_state_nxt = COMPARE;
        else if (w_to_hit) w_state_nxt = DONE;
      end
      COMPARE: w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_sig_nxt  = r_sig;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = r_done;
    w_pass_nxt = r_pass;
    w_busy_nxt = (w_state_nxt == COMPACT) || (w_state_nxt == COMPARE);
`ifdef MISR_TIMEOUT_EN
    w_idle_nxt    = r_idle;
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (w_start_ok) begin
          w_sig_nxt  = SEED;
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b0;
          w_pass_nxt = 1'b0;
`ifdef MISR_TIMEOUT_EN
          w_idle_nxt    = '0;
          w_timeout_nxt = 1'b0;
`endif
        end
      end
      COMPACT: begin
        if (bus.sample_valid) begin
          w_sig_nxt = w_misr;
          w_cnt_nxt = w_cnt_inc;
`ifdef MISR_TIMEOUT_EN
          w_idle_nxt = '0;
`endif
        end else begin
`ifdef MISR_TIMEOUT_EN
          w_idle_nxt = r_idle + IDLE_W'(1);
`endif
          if (w_to_hit) begin
            w_done_nxt = 1'b1;
            w_pass_nxt = 1'b0;
`ifdef MISR_TIMEOUT_EN
            w_timeout_nxt = 1'b1;
`endif
          end
        end
      end
      COMPARE: begin
        w_done_nxt = 1'b1;
        w_pass_nxt = (r_sig == bus.golden_sig);
      end
      default: ;
    endcase
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.signature    = r_sig;
  assign bus.sample_count = r_cnt;
`ifdef MISR_TIMEOUT_EN
  assign bus.timeout      = r_timeout;
`endif

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// tb/tb_bist_misr_analyzer.sv - scoreboard testbench for bist_misr_analyzer

module tb_bist_misr_analyzer;

  typedef struct {
    logic       pass;
    logic [3:0] sig;
    logic [7:0] cnt;
    logic       to;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];
  logic prev_done;

  bist_misr_analyzer_if #(.WIDTH(4), .CNT_W(8)) bus ();

  bist_misr_analyzer #(
    .WIDTH (4),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic [3:0] s, input logic [7:0] c, input logic t);
    exp_t e;
    e.pass = p;
    e.sig  = s;
    e.cnt  = c;
    e.to   = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge of done is matched against the oldest expected result
  initial begin
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pass", {31'd0, bus.pass}, {31'd0, e.pass});
          chk("sb_signature", {28'd0, bus.signature}, {28'd0, e.sig});
          chk("sb_count", {24'd0, bus.sample_count}, {24'd0, e.cnt});
`ifdef MISR_TIMEOUT_EN
          chk("sb_timeout", {31'd0, bus.timeout}, {31'd0, e.to});
`endif
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data = 4'h0;
    bus.expected_count = 8'd0;
    bus.golden_sig = 4'h0;
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_pass", {31'd0, bus.pass}, 32'd0);
    chk("rst_sig", {28'd0, bus.signature}, 32'd0);
    chk("rst_cnt", {24'd0, bus.sample_count}, 32'd0);
    rst_n = 1'b1;

    // Run, pass: 8 then 0 -> 8 then 3
    bus.expected_count = 8'd2;
    bus.golden_sig = 4'h3;
    bus.start = 1'b1;
    push(1'b1, 4'h3, 8'd2, 1'b0);
    step();
    bus.start = 1'b0;
    chk("t1_busy_after_start", {31'd0, bus.busy}, 32'd1);
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h8;
    step();
    chk("t1_sig1", {28'd0, bus.signature}, 32'h8);
    chk("t1_cnt1", {24'd0, bus.sample_count}, 32'd1);
    bus.sample_data = 4'h0;
    step();
    chk("t1_sig2", {28'd0, bus.signature}, 32'h3);
    chk("t1_done_not_yet", {31'd0, bus.done}, 32'd0);
    bus.sample_valid = 1'b0;
    step();
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);

    // Run, fail (start from DONE)
    bus.golden_sig = 4'h4;
    bus.start = 1'b1;
    push(1'b0, 4'h3, 8'd2, 1'b0);
    step();
    bus.start = 1'b0;
    chk("t2_done_drop", {31'd0, bus.done}, 32'd0);
    chk("t2_seed_reload", {28'd0, bus.signature}, 32'h0);
    chk("t2_cnt_clear", {24'd0, bus.sample_count}, 32'd0);
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h8;
    step();
    bus.sample_data = 4'h0;
    step();
    bus.sample_valid = 1'b0;
    step();
    chk("t2_done", {31'd0, bus.done}, 32'd1);

    // Zero-length run; stray sample in DONE is ignored
    bus.expected_count = 8'd0;
    bus.golden_sig = 4'h0;
    bus.start = 1'b1;
    push(1'b1, 4'h0, 8'd0, 1'b0);
    step();
    bus.start = 1'b0;
    chk("t3_busy", {31'd0, bus.busy}, 32'd1);
    chk("t3_done_not_yet", {31'd0, bus.done}, 32'd0);
    step();
    chk("t3_done", {31'd0, bus.done}, 32'd1);
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'hF;
    step();
    bus.sample_valid = 1'b0;
    chk("t3_done_ignores_sample", {28'd0, bus.signature}, 32'h0);

    // Gaps plus start during COMPACT: 1, 3 idle cycles, 2 -> 0
    bus.expected_count = 8'd2;
    bus.golden_sig = 4'h0;
    bus.start = 1'b1;
    push(1'b1, 4'h0, 8'd2, 1'b0);
    step();
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h1;
    step();
    bus.sample_valid = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("t4_gap_sig", {28'd0, bus.signature}, 32'h1);
    chk("t4_start_ignored_cnt", {24'd0, bus.sample_count}, 32'd1);
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h2;
    step();
    bus.sample_valid = 1'b0;
    chk("t4_sig", {28'd0, bus.signature}, 32'h0);
    chk("t4_cnt", {24'd0, bus.sample_count}, 32'd2);
    step();

    // Maximum count: 1 then 254 zeros -> x^254 mod (x^4+x+1) = x^14 = x^3+1
    bus.expected_count = 8'd255;
    bus.golden_sig = 4'h9;
    bus.start = 1'b1;
    push(1'b1, 4'h9, 8'd255, 1'b0);
    step();
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h1;
    step();
    bus.sample_data = 4'h0;
    repeat (254) step();
    chk("t5_cnt_max", {24'd0, bus.sample_count}, 32'd255);
    chk("t5_sig", {28'd0, bus.signature}, 32'h9);
    step();
    bus.sample_valid = 1'b0;
    chk("t5_cnt_no_wrap", {24'd0, bus.sample_count}, 32'd255);
    chk("t5_done", {31'd0, bus.done}, 32'd1);

`ifdef MISR_TIMEOUT_EN
    // Timeout: one sample then 16 idle cycles
    bus.expected_count = 8'd4;
    bus.golden_sig = 4'h1;
    bus.start = 1'b1;
    push(1'b0, 4'h1, 8'd1, 1'b1);
    step();
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h1;
    step();
    bus.sample_valid = 1'b0;
    repeat (15) step();
    chk("t6_not_yet", {31'd0, bus.done}, 32'd0);
    step();
    chk("t6_done", {31'd0, bus.done}, 32'd1);
    chk("t6_timeout", {31'd0, bus.timeout}, 32'd1);
    chk("t6_pass", {31'd0, bus.pass}, 32'd0);
`endif

    // Reset mid-run
    bus.expected_count = 8'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`ifdef MISR_TIMEOUT_EN
    chk("t7_timeout_cleared", {31'd0, bus.timeout}, 32'd0);
`endif
    bus.sample_valid = 1'b1;
    bus.sample_data = 4'h5;
    step();
    chk("t7_cnt1", {24'd0, bus.sample_count}, 32'd1);
    rst_n = 1'b0;
    bus.sample_data = 4'h7;
    step();
    chk("t7_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t7_rst_done", {31'd0, bus.done}, 32'd0);
    chk("t7_rst_sig", {28'd0, bus.signature}, 32'h0);
    chk("t7_rst_cnt", {24'd0, bus.sample_count}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("t7_idle_sig", {28'd0, bus.signature}, 32'h0);
    chk("t7_idle_cnt", {24'd0, bus.sample_count}, 32'd0);
    chk("t7_idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.sample_valid = 1'b0;
    step();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
